// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single RAM port between the coherence controller (data side) and
// the instruction-fetch requests of two cores. The controller sees what looks
// like a private RAM: its request is forwarded and the RAM state and load data
// come back to it.
//
// A data block is two words. Once the first word completes, the port stays
// locked to the data side for up to LOCK_GAP idle cycles, so a writeback,
// forward-writeback or block load is never split by an instruction fetch.
// Instruction fetches alternate between the two cores (round-robin). A
// starvation counter lets a pending fetch win after STARVE_LIMIT data words.
//
// Parameters
//   LOCK_GAP       idle cycles tolerated between word 1 and word 2 of a block
//   STARVE_LIMIT   data words completed, with a fetch pending, before the
//                  fetch is given priority in IDLE
//
// Ports
//   CLK, nRST            clock; asynchronous active-low reset
//   iREN_i[1:0]          instruction read request, one bit per core
//   iaddr_i[1:0]         instruction address, one word per core
//   iwait_o[1:0]         instruction wait, one bit per core
//   iload_o[1:0]         instruction data, one word per core
//   cc_ramREN_i/WEN_i    coherence controller read / write request
//   cc_ramaddr_i         coherence controller address
//   cc_ramstore_i        coherence controller write data
//   cc_ramstate_o        RAM state as seen by the coherence controller
//   cc_ramload_o         read data returned to the coherence controller
//   ramREN_o/ramWEN_o    RAM read / write enable
//   ramaddr_o/ramstore_o RAM address / write data
//   ramload_i            RAM read data
//   ramstate_i           RAM state: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int LOCK_GAP     = 3,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [1:0]       iREN_i,
  input  logic [1:0][31:0] iaddr_i,
  output logic [1:0]       iwait_o,
  output logic [1:0][31:0] iload_o,
  input  logic             cc_ramREN_i,
  input  logic             cc_ramWEN_i,
  input  logic [31:0]      cc_ramaddr_i,
  input  logic [31:0]      cc_ramstore_i,
  output logic [1:0]       cc_ramstate_o,
  output logic [31:0]      cc_ramload_o,
  output logic             ramREN_o,
  output logic             ramWEN_o,
  output logic [31:0]      ramaddr_o,
  output logic [31:0]      ramstore_o,
  input  logic [31:0]      ramload_i,
  input  logic [1:0]       ramstate_i
);

  // RAM state encodings (ERROR = 2'd3 is simply "not ACCESS" here)
  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;

  localparam int GAP_W    = (LOCK_GAP < 1) ? 1 : $clog2(LOCK_GAP + 1);
  localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  localparam logic [GAP_W-1:0]    GAP_MAX    = GAP_W'(LOCK_GAP);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    DHOLD  = 2'd2,
    IGRANT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                rr_q, rr_d;
  logic                word_q, word_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                igr_q, igr_d;

  logic dreq;
  logic d_ren;
  logic any_i;
  logic pick;
  logic starved;
  logic ram_acc;

  assign dreq    = cc_ramREN_i | cc_ramWEN_i;
  // A simultaneous read and write from the controller is treated as a write.
  assign d_ren   = cc_ramREN_i & ~cc_ramWEN_i;
  assign any_i   = |iREN_i;
  // Favour core rr if it is asking, otherwise the other core.
  assign pick    = iREN_i[rr_q] ? rr_q : ~rr_q;
  assign starved = (starve_q == STARVE_MAX) && any_i;
  assign ram_acc = (ramstate_i == RS_ACCESS);

  assign cc_ramload_o = ramload_i;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      word_q   <= 1'b0;
      gap_q    <= '0;
      starve_q <= '0;
      igr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      word_q   <= word_d;
      gap_q    <= gap_d;
      starve_q <= starve_d;
      igr_q    <= igr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    word_d        = word_q;
    gap_d         = gap_q;
    starve_d      = starve_q;
    igr_d         = igr_q;
    iwait_o       = 2'b11;
    iload_o       = '0;
    cc_ramstate_o = RS_BUSY;
    ramREN_o      = 1'b0;
    ramWEN_o      = 1'b0;
    ramaddr_o     = '0;
    ramstore_o    = '0;

    // Outputs must fall to their idle values the moment reset asserts, even
    // while requests are still present on the inputs.
    if (nRST) begin
      unique case (state_q)
        IDLE: begin
          // Arbitration is combinational so the winner reaches RAM this cycle.
          if (starved || (!dreq && any_i)) begin
            igr_d     = pick;
            state_d   = IGRANT;
            ramREN_o  = 1'b1;
            ramaddr_o = iaddr_i[pick];
          end else if (dreq) begin
            state_d    = DGRANT;
            ramREN_o   = d_ren;
            ramWEN_o   = cc_ramWEN_i;
            ramaddr_o  = cc_ramaddr_i;
            ramstore_o = cc_ramstore_i;
          end
        end

        DGRANT: begin
          cc_ramstate_o = ramstate_i;
          if (!dreq) begin
            // Controller withdrew before completion; word index kept.
            state_d = IDLE;
          end else begin
            ramREN_o   = d_ren;
            ramWEN_o   = cc_ramWEN_i;
            ramaddr_o  = cc_ramaddr_i;
            ramstore_o = cc_ramstore_i;
            if (ram_acc) begin
              if (any_i && (starve_q != STARVE_MAX))
                starve_d = starve_q + STARVE_W'(1);
              if (!word_q) begin
                word_d  = 1'b1;
                gap_d   = '0;
                state_d = DHOLD;
              end else begin
                word_d  = 1'b0;
                state_d = IDLE;
              end
            end
          end
        end

        DHOLD: begin
          // Port is locked to the data side between the two words of a block;
          // fetches stay blocked here regardless of the starvation count.
          cc_ramstate_o = RS_FREE;
          if (dreq) begin
            state_d    = DGRANT;
            ramREN_o   = d_ren;
            ramWEN_o   = cc_ramWEN_i;
            ramaddr_o  = cc_ramaddr_i;
            ramstore_o = cc_ramstore_i;
          end else begin
            gap_d = gap_q + GAP_W'(1);
            if (gap_d == GAP_MAX) begin
              word_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end

        IGRANT: begin
          ramREN_o       = 1'b1;
          ramaddr_o      = iaddr_i[igr_q];
          iload_o[igr_q] = ramload_i;
          iwait_o[igr_q] = ~ram_acc;
          if (ram_acc) begin
            rr_d     = ~igr_q;
            starve_d = '0;
            state_d  = IDLE;
          end else if (!iREN_i[igr_q]) begin
            state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. A small RAM model answers ACCESS after a
// configurable number of cycles with the request held; read data is the
// address XOR 32'hA5A5_0000 so expected load values are easy to derive.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam logic [1:0] FREE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [1:0][31:0] iload;
  logic             cc_ramREN, cc_ramWEN;
  logic [31:0]      cc_ramaddr, cc_ramstore;
  logic [1:0]       cc_ramstate;
  logic [31:0]      cc_ramload;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;

  int checks = 0;
  int errors = 0;

  int ram_lat = 2;
  int ram_cnt;

  mem_arbiter #(.LOCK_GAP(3), .STARVE_LIMIT(8)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .iREN_i       (iREN),
    .iaddr_i      (iaddr),
    .iwait_o      (iwait),
    .iload_o      (iload),
    .cc_ramREN_i  (cc_ramREN),
    .cc_ramWEN_i  (cc_ramWEN),
    .cc_ramaddr_i (cc_ramaddr),
    .cc_ramstore_i(cc_ramstore),
    .cc_ramstate_o(cc_ramstate),
    .cc_ramload_o (cc_ramload),
    .ramREN_o     (ramREN),
    .ramWEN_o     (ramWEN),
    .ramaddr_o    (ramaddr),
    .ramstore_o   (ramstore),
    .ramload_i    (ramload),
    .ramstate_i   (ramstate)
  );

  always #5 CLK = ~CLK;

  // RAM model: ACCESS once the enable has been held for ram_lat edges.
  assign ramstate = !(ramREN | ramWEN) ? FREE : (ram_cnt >= ram_lat) ? ACC : BUSY;
  assign ramload  = ramaddr ^ 32'hA5A5_0000;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) ram_cnt <= 0;
    else if (!(ramREN | ramWEN) || ramstate == ACC) ram_cnt <= 0;
    else ram_cnt <= ram_cnt + 1;
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  // Advance until the controller sees ACCESS (bounded). Records whether REN and
  // WEN were ever both driven and whether any iwait ever dropped.
  task automatic wait_access(output int lat, output logic ov, output logic ig);
    lat = 0;
    ov  = ramREN & ramWEN;
    ig  = (iwait !== 2'b11);
    while (cc_ramstate !== ACC && lat < 20) begin
      cyc();
      smp();
      lat++;
      ov = ov | (ramREN & ramWEN);
      ig = ig | (iwait !== 2'b11);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0; iREN = 2'b00; iaddr = '0;
    cc_ramREN = 1'b0; cc_ramWEN = 1'b0; cc_ramaddr = '0; cc_ramstore = '0;
    #2;
    checks++;
    if ({iwait, cc_ramstate, ramREN, ramWEN} !== {2'b11, BUSY, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected %b", {iwait, cc_ramstate, ramREN, ramWEN}, {2'b11, BUSY, 2'b00});
    end
    smp();
    checks++;
    if ({iload, ramaddr, ramstore} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data got %h expected 0", {iload, ramaddr, ramstore});
    end
    @(posedge CLK); #1; nRST = 1'b1;
  endtask

  task automatic test_single_fetch();
    cyc();
    iREN = 2'b01; iaddr[0] = 32'h100;
    smp();
    checks++;
    if ({ramREN, ramWEN, ramaddr, iwait} !== {1'b1, 1'b0, 32'h100, 2'b11}) begin
      errors++;
      $display("FAIL fetch_issue got %h expected %h", {ramREN, ramWEN, ramaddr, iwait}, {2'b10, 32'h100, 2'b11});
    end
    cyc(); smp();
    checks++;
    if (iwait !== 2'b11) begin
      errors++;
      $display("FAIL fetch_wait got %b expected 11", iwait);
    end
    cyc(); smp();
    checks++;
    if ({iwait, iload[0], iload[1]} !== {2'b10, 32'hA5A5_0100, 32'h0}) begin
      errors++;
      $display("FAIL fetch_access got %h expected %h", {iwait, iload[0], iload[1]}, {2'b10, 32'hA5A5_0100, 32'h0});
    end
    cyc();
    iREN = 2'b00;
    smp();
    checks++;
    if ({ramREN, iwait} !== {1'b0, 2'b11}) begin
      errors++;
      $display("FAIL fetch_release got %b expected 011", {ramREN, iwait});
    end
  endtask

  // rr is 1 after the single core0 fetch, so core1 goes first.
  task automatic test_round_robin();
    cyc();
    iREN = 2'b11; iaddr[0] = 32'h200; iaddr[1] = 32'h300;
    for (int k = 0; k < 4; k++) begin
      logic        c;
      logic [31:0] a;
      c = (k % 2 == 0);
      a = c ? 32'h300 : 32'h200;
      smp();
      checks++;
      if ({ramREN, ramaddr} !== {1'b1, a}) begin
        errors++;
        $display("FAIL rr_grant%0d got %h expected %h", k, {ramREN, ramaddr}, {1'b1, a});
      end
      cyc(); smp();
      cyc(); smp();
      checks++;
      if ({iwait, iload[c]} !== {(c ? 2'b01 : 2'b10), a ^ 32'hA5A5_0000}) begin
        errors++;
        $display("FAIL rr_done%0d got %h expected %h", k, {iwait, iload[c]}, {(c ? 2'b01 : 2'b10), a ^ 32'hA5A5_0000});
      end
      cyc();
    end
    iREN = 2'b00;
    smp();
  endtask

  task automatic test_writeback();
    int   lat;
    logic ov, ig;
    cyc();
    iREN = 2'b10; iaddr[1] = 32'h400;
    cc_ramWEN = 1'b1; cc_ramREN = 1'b1; cc_ramaddr = 32'h800; cc_ramstore = 32'h1111;
    smp();
    checks++;
    if ({ramWEN, ramREN, ramaddr, ramstore} !== {2'b10, 32'h800, 32'h1111}) begin
      errors++;
      $display("FAIL wb_word0_issue got %h expected %h", {ramWEN, ramREN, ramaddr, ramstore}, {2'b10, 32'h800, 32'h1111});
    end
    wait_access(lat, ov, ig);
    checks++;
    if ({lat, ov, ig} !== {32'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wb_word0 got lat %0d ov %b ig %b expected lat 2 ov 0 ig 0", lat, ov, ig);
    end
    cyc();
    cc_ramWEN = 1'b0; cc_ramREN = 1'b0;
    smp();
    checks++;
    if ({ramREN, ramWEN, cc_ramstate} !== {2'b00, FREE}) begin
      errors++;
      $display("FAIL wb_hold got %b expected 0000", {ramREN, ramWEN, cc_ramstate});
    end
    cyc();
    cc_ramWEN = 1'b1; cc_ramaddr = 32'h804; cc_ramstore = 32'h2222;
    smp();
    checks++;
    if ({ramWEN, ramREN, ramaddr, ramstore} !== {2'b10, 32'h804, 32'h2222}) begin
      errors++;
      $display("FAIL wb_word1_issue got %h expected %h", {ramWEN, ramREN, ramaddr, ramstore}, {2'b10, 32'h804, 32'h2222});
    end
    wait_access(lat, ov, ig);
    checks++;
    if ({lat, ov, ig} !== {32'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wb_word1 got lat %0d ov %b ig %b expected lat 2 ov 0 ig 0", lat, ov, ig);
    end
    cyc();
    cc_ramWEN = 1'b0;
    smp();
    checks++;
    if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h400}) begin
      errors++;
      $display("FAIL wb_then_fetch got %h expected %h", {ramREN, ramWEN, ramaddr}, {2'b10, 32'h400});
    end
    cyc(); smp(); cyc(); smp();
    checks++;
    if ({iwait, iload[1]} !== {2'b01, 32'hA5A5_0400}) begin
      errors++;
      $display("FAIL wb_fetch_done got %h expected %h", {iwait, iload[1]}, {2'b01, 32'hA5A5_0400});
    end
    cyc();
    iREN = 2'b00;
    smp();
  endtask

  task automatic test_lock_gap();
    int   lat;
    logic ov, ig;
    // Two-cycle gap: lock holds.
    cyc();
    iREN = 2'b01; iaddr[0] = 32'h500;
    cc_ramWEN = 1'b1; cc_ramaddr = 32'h900; cc_ramstore = 32'h3333;
    smp();
    wait_access(lat, ov, ig);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL gap2_word0 got lat %0d expected 2", lat);
    end
    for (int g = 1; g <= 2; g++) begin
      cyc();
      cc_ramWEN = 1'b0;
      smp();
      checks++;
      if ({ramREN, ramWEN} !== 2'b00) begin
        errors++;
        $display("FAIL gap2_idle%0d got %b expected 00", g, {ramREN, ramWEN});
      end
    end
    cyc();
    cc_ramWEN = 1'b1; cc_ramaddr = 32'h904;
    smp();
    checks++;
    if ({ramWEN, ramREN, ramaddr} !== {2'b10, 32'h904}) begin
      errors++;
      $display("FAIL gap2_lock_held got %h expected %h", {ramWEN, ramREN, ramaddr}, {2'b10, 32'h904});
    end
    wait_access(lat, ov, ig);
    cyc();
    cc_ramWEN = 1'b0;
    smp();
    checks++;
    if ({ramREN, ramaddr} !== {1'b1, 32'h500}) begin
      errors++;
      $display("FAIL gap2_fetch got %h expected %h", {ramREN, ramaddr}, {1'b1, 32'h500});
    end
    cyc(); smp(); cyc(); smp();
    cyc();
    iREN = 2'b00;
    // Four-cycle gap: lock drops after the third idle cycle.
    cyc();
    iREN = 2'b01;
    cc_ramWEN = 1'b1; cc_ramaddr = 32'hA00;
    smp();
    wait_access(lat, ov, ig);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL gap4_word0 got lat %0d expected 2", lat);
    end
    for (int g = 1; g <= 3; g++) begin
      cyc();
      cc_ramWEN = 1'b0;
      smp();
      checks++;
      if ({ramREN, ramWEN} !== 2'b00) begin
        errors++;
        $display("FAIL gap4_idle%0d got %b expected 00", g, {ramREN, ramWEN});
      end
    end
    cyc(); smp();
    checks++;
    if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h500}) begin
      errors++;
      $display("FAIL gap4_fetch got %h expected %h", {ramREN, ramWEN, ramaddr}, {2'b10, 32'h500});
    end
    cyc();
    cc_ramWEN = 1'b1; cc_ramaddr = 32'hA04;
    smp();
    checks++;
    if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h500}) begin
      errors++;
      $display("FAIL gap4_fetch_kept got %h expected %h", {ramREN, ramWEN, ramaddr}, {2'b10, 32'h500});
    end
    cyc(); smp();
    checks++;
    if (iwait !== 2'b10) begin
      errors++;
      $display("FAIL gap4_fetch_done got %b expected 10", iwait);
    end
    cyc();
    iREN = 2'b00;
    smp();
    checks++;
    if ({ramWEN, ramaddr} !== {1'b1, 32'hA04}) begin
      errors++;
      $display("FAIL gap4_data_return got %h expected %h", {ramWEN, ramaddr}, {1'b1, 32'hA04});
    end
    wait_access(lat, ov, ig);
    cyc();
    cc_ramWEN = 1'b0;
    smp();
    // Lock was dropped, so this access was word 0 and the block is held again.
    checks++;
    if (cc_ramstate !== FREE) begin
      errors++;
      $display("FAIL gap4_word_reset got %0d expected %0d", cc_ramstate, FREE);
    end
    for (int g = 0; g < 4; g++) cyc();
    smp();
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic ov, ig;
    cyc();
    iREN = 2'b01; iaddr[0] = 32'hC00;
    cc_ramWEN = 1'b1; cc_ramstore = 32'h5555;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      cc_ramaddr = 32'h1000 + 32'(4 * k);
      smp();
      checks++;
      if ({ramWEN, ramREN, ramaddr} !== {2'b10, 32'h1000 + 32'(4 * k)}) begin
        errors++;
        $display("FAIL b2b_issue%0d got %h expected %h", k, {ramWEN, ramREN, ramaddr}, {2'b10, 32'h1000 + 32'(4 * k)});
      end
      wait_access(lat, ov, ig);
      checks++;
      if ({lat, ig} !== {32'd2, 1'b0}) begin
        errors++;
        $display("FAIL b2b_word%0d got lat %0d ig %b expected lat 2 ig 0", k, lat, ig);
      end
    end
    cyc();
    cc_ramaddr = 32'h1020;
    smp();
    checks++;
    if ({ramREN, ramWEN, ramaddr, cc_ramstate} !== {2'b10, 32'hC00, BUSY}) begin
      errors++;
      $display("FAIL starve_grant got %h expected %h", {ramREN, ramWEN, ramaddr, cc_ramstate}, {2'b10, 32'hC00, BUSY});
    end
    cyc(); smp(); cyc(); smp();
    checks++;
    if ({iwait, iload[0]} !== {2'b10, 32'hA5A5_0C00}) begin
      errors++;
      $display("FAIL starve_fetch_done got %h expected %h", {iwait, iload[0]}, {2'b10, 32'hA5A5_0C00});
    end
    cyc(); smp();
    checks++;
    if ({ramWEN, ramREN, ramaddr} !== {2'b10, 32'h1020}) begin
      errors++;
      $display("FAIL starve_cleared got %h expected %h", {ramWEN, ramREN, ramaddr}, {2'b10, 32'h1020});
    end
    cyc();
    cc_ramWEN = 1'b0; iREN = 2'b00;
    cyc(); smp();
  endtask

  task automatic test_reset_mid();
    int   lat;
    logic ov, ig;
    cyc();
    cc_ramWEN = 1'b1; cc_ramaddr = 32'h2000; cc_ramstore = 32'h7777;
    smp();
    wait_access(lat, ov, ig);
    cyc();
    cc_ramWEN = 1'b0;
    cyc();
    ram_lat = 10;
    cc_ramWEN = 1'b1; cc_ramaddr = 32'h2004;
    cyc(); smp();
    checks++;
    if ({ramWEN, ramaddr, cc_ramstate} !== {1'b1, 32'h2004, BUSY}) begin
      errors++;
      $display("FAIL rst_pre got %h expected %h", {ramWEN, ramaddr, cc_ramstate}, {1'b1, 32'h2004, BUSY});
    end
    #2;
    nRST = 1'b0;
    #1;
    checks++;
    if ({ramWEN, ramREN, cc_ramstate, iwait} !== {2'b00, BUSY, 2'b11}) begin
      errors++;
      $display("FAIL rst_async got %b expected %b", {ramWEN, ramREN, cc_ramstate, iwait}, {2'b00, BUSY, 2'b11});
    end
    cyc();
    cc_ramWEN = 1'b0; ram_lat = 2;
    cyc();
    nRST = 1'b1;
    cyc();
    cc_ramREN = 1'b1; cc_ramaddr = 32'h3000;
    smp();
    checks++;
    if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h3000}) begin
      errors++;
      $display("FAIL rst_after_issue got %h expected %h", {ramREN, ramWEN, ramaddr}, {2'b10, 32'h3000});
    end
    wait_access(lat, ov, ig);
    checks++;
    if ({lat, cc_ramload} !== {32'd2, 32'hA5A5_3000}) begin
      errors++;
      $display("FAIL rst_after_load got lat %0d data %h expected lat 2 data a5a53000", lat, cc_ramload);
    end
    cyc();
    cc_ramREN = 1'b0;
    smp();
    checks++;
    if (cc_ramstate !== FREE) begin
      errors++;
      $display("FAIL rst_word_zero got %0d expected %0d", cc_ramstate, FREE);
    end
    for (int g = 0; g < 4; g++) cyc();
    smp();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_writeback();
    test_lock_gap();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
